// File: rtl/pearson_pkg.sv
// Shared types and the default Pearson permutation T[x] = (167*x + 13) mod 256.
package pearson_pkg;

    typedef logic [7:0] lane_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic [2047:0] pearson_build_tbl();
        logic [2047:0] t;
        t = '0;
        for (int x = 0; x < 256; x++) begin
            t[8*x +: 8] = 8'((167 * x + 13) % 256);
        end
        return t;
    endfunction

    localparam logic [2047:0] PEARSON_DEFAULT_TABLE = pearson_build_tbl();

endpackage

// File: rtl/pearson_lane.sv
// One Pearson lane: seed select, lookup address and the running hash byte.
module pearson_lane
    import pearson_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic  clock,
    input  logic  reset_n,
    input  logic  step,
    input  logic  first,
    input  lane_t cur,
    output lane_t lookup_addr,
    input  lane_t lookup_data,
    output lane_t h
);

    // First byte is offset by the lane index so lanes diverge.
    always_comb begin
        lookup_addr = first ? (cur + lane_t'(LANE)) : (h ^ cur);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            h <= '0;
        end else if (step) begin
            h <= lookup_data;
        end
    end

endmodule

// File: rtl/pearson_hash_stream.sv
// Byte-serial multi-lane Pearson hash with valid/ready on both sides.
// Define PEARSON_TABLE_LOAD_EN for a writable table (tbl_* ports).
module pearson_hash_stream
    import pearson_pkg::*;
#(
    parameter int MSG_BYTES  = 4,
    parameter int HASH_BYTES = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*MSG_BYTES-1:0]  message,
    output logic                    hash_valid,
    input  logic                    hash_ready,
`ifdef PEARSON_TABLE_LOAD_EN
    output logic [8*HASH_BYTES-1:0] hash,
    input  logic                    tbl_we,
    input  logic [7:0]              tbl_addr,
    input  logic [7:0]              tbl_data
`else
    output logic [8*HASH_BYTES-1:0] hash
`endif
);

    localparam int CW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [8*MSG_BYTES-1:0]    msg;
    lane_t                     cur;
    logic                      accept;
    logic                      step;
    logic                      first;
    logic                      last;
    lane_t                     addr [HASH_BYTES];
    lane_t                     data [HASH_BYTES];
    lane_t                     h    [HASH_BYTES];
    logic [8*HASH_BYTES-1:0]   lanes;

    assign accept = in_valid && in_ready;
    assign step   = (state == ST_RUN);
    assign first  = (cnt == '0);
    assign last   = (cnt == CW'(MSG_BYTES - 1));
    assign cur    = msg[{cnt, 3'b000} +: 8];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            msg        <= '0;
            in_ready   <= 1'b1;
            hash_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        msg      <= message;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last) begin
                        cnt        <= '0;
                        hash_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Return to IDLE only; accepting resumes a cycle later.
                    if (hash_ready) begin
                        hash_valid <= 1'b0;
                        in_ready   <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PEARSON_TABLE_LOAD_EN
    lane_t tbl [256];
    logic  tbl_wr;

    assign tbl_wr = tbl_we && (state == ST_IDLE) && !accept;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) begin
                tbl[i] <= PEARSON_DEFAULT_TABLE[8*i +: 8];
            end
        end else if (tbl_wr) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end
`endif

    for (genvar j = 0; j < HASH_BYTES; j++) begin : g_lane
        pearson_lane #(
            .LANE(j)
        ) u_lane (
            .clock       (clock),
            .reset_n     (reset_n),
            .step        (step),
            .first       (first),
            .cur         (cur),
            .lookup_addr (addr[j]),
            .lookup_data (data[j]),
            .h           (h[j])
        );
`ifdef PEARSON_TABLE_LOAD_EN
        assign data[j] = tbl[addr[j]];
`else
        assign data[j] = PEARSON_DEFAULT_TABLE[{addr[j], 3'b000} +: 8];
`endif
        assign lanes[8*j +: 8] = h[j];
    end

    assign hash = hash_valid ? lanes : '0;

endmodule

// File: doc/pearson_hash_stream.md
PEARSON_HASH_STREAM -- requirements
Module: pearson_hash_stream

Interface
REQ-001 SHALL have parameter MSG_BYTES, default 4, message length in bytes (1..16).
REQ-002 SHALL have parameter HASH_BYTES, default 2, hash width in bytes (1..8); each byte is an independent Pearson lane.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  message offered.
REQ-006 SHALL have port in_ready  output  1  block can accept a message.
REQ-007 SHALL have port message  input  8*MSG_BYTES  message; byte i = message[8i+7:8i].
REQ-008 SHALL have port hash_valid  output  1  hash result available.
REQ-009 SHALL have port hash_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port hash  output  8*HASH_BYTES  result; lane j = hash[8j+7:8j].
REQ-011 SHALL have ports tbl_we  input  1, tbl_addr  input  8, tbl_data  input  8 (table write; present only with PEARSON_TABLE_LOAD_EN).

Function
REQ-012 SHALL compute for each lane j: h = T[(byte0 + j) mod 256]; then for i = 1..MSG_BYTES-1: h = T[h XOR byte i]; all arithmetic 8-bit, wrapping.
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; in_valid & in_ready at an edge captures message and enters RUN.
REQ-015 SHALL process one message byte per cycle in RUN, all lanes in parallel, using a byte counter 0..MSG_BYTES-1.
REQ-016 SHALL enter DONE at the edge that processes byte MSG_BYTES-1; hash_valid rises exactly MSG_BYTES cycles after the accepting edge.
REQ-017 SHALL hold hash and hash_valid stable in DONE until hash_valid & hash_ready, then return to IDLE.
REQ-018 SHALL drive hash = 0 whenever hash_valid = 0.
REQ-019 SHALL ignore in_valid outside IDLE; the message is not re-sampled during RUN.
REQ-020 SHALL, for MSG_BYTES = 1, enter DONE on the edge after acceptance (latency 1).
REQ-021 SHALL not combinationally depend on hash_ready for in_ready; no back-to-back accept in the DONE->IDLE cycle.

Reset
REQ-022 SHALL on reset_n = 0 at an edge: FSM to IDLE, counter 0, lane registers 0, hash_valid 0, in_ready 1 from the next cycle.
REQ-023 SHALL abort any in-flight RUN or DONE on reset with no result output.
REQ-024 SHALL with PEARSON_TABLE_LOAD_EN reload the table with PEARSON_DEFAULT_TABLE on reset.

Configuration
REQ-025 SHALL, with PEARSON_TABLE_LOAD_EN defined, hold the table in a 256x8 register array; tbl_we writes tbl_data to tbl_addr only in IDLE and without simultaneous in_valid & in_ready; writes in other cycles are dropped.
REQ-026 SHALL, without PEARSON_TABLE_LOAD_EN, use PEARSON_DEFAULT_TABLE as a constant ROM; tbl_* ports absent.

Structure
REQ-027 SHALL take PEARSON_DEFAULT_TABLE (T[x] = (167*x + 13) mod 256), the FSM state typedef and lane byte typedef from shared package pearson_pkg.
REQ-028 SHALL instantiate one sub-module pearson_lane per lane (lane register, seed select, T lookup); table storage stays in the top level.

Verification
REQ-029 SHALL cover: MSG_BYTES=1, HASH_BYTES=2, message 0x00 -> hash 0xB40D, hash_valid 1 cycle after accept.
REQ-030 SHALL cover: MSG_BYTES=2, HASH_BYTES=1, message 0x0000 -> hash 0x88, hash_valid 2 cycles after accept.
REQ-031 SHALL cover: hash_ready held 0 for 5 cycles in DONE -> hash stable, in_ready 0 throughout; accepted on the 6th cycle -> IDLE next cycle.
REQ-032 SHALL cover: reset_n = 0 mid-RUN (defaults) -> next cycle IDLE, hash_valid 0, hash 0, no result.
REQ-033 SHALL cover (macro on): write T[0] = 0x55 in IDLE, MSG_BYTES=1, HASH_BYTES=1, message 0x00 -> hash 0x55; same write attempted in RUN -> dropped, table unchanged.
REQ-034 SHALL cover: in_valid toggling during RUN with a different message -> result matches the originally captured message.
